alu4_result_checker: RTL and testbench

- Synthesizable checking end for the 4-bit two-operand ALU (opcode, a_in, b_in → y_out).
- Samples each applied operation together with the ALU's returned result and recomputes the expected result with its own golden model.
- Counts passes and fails, raises a pulse on each mismatch, and captures the first failing transaction for readout.
- Sits beside the ALU on-chip or in a self-checking bench. The stimulus driver and this checker together form a closed loop.

---
 rtl/alu4_result_checker.sv | 125 ++++++++++++
 tb/tb_alu4_result_checker.sv | 207 ++++++++++++++++++++
 2 files changed

// File: rtl/alu4_result_checker.sv
// Result checker for the 4-bit two-operand ALU: recomputes each result with a golden
// model, counts passes/fails, pulses on mismatch and captures the first failure.
module alu4_result_checker #(
    parameter int CNT_W        = 8,
    parameter bit STOP_ON_FAIL = 1'b0
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             clear_in,
    input  logic             valid_in,
    input  logic [1:0]       opcode_in,
    input  logic [3:0]       a_in,
    input  logic [3:0]       b_in,
    input  logic [3:0]       y_in,
    output logic [CNT_W-1:0] pass_count_out,
    output logic [CNT_W-1:0] fail_count_out,
    output logic             mismatch_out,
    output logic             first_fail_valid_out,
    output logic [1:0]       first_fail_op_out,
    output logic [3:0]       first_fail_a_out,
    output logic [3:0]       first_fail_b_out,
    output logic [3:0]       first_fail_y_out,
    output logic [3:0]       first_fail_exp_out,
    output logic             halted_out
);

    typedef enum logic [1:0] {IDLE, RUN, HALT} state_t;

    state_t     state;
    logic       s1_vld;
    logic [1:0] s1_op;
    logic [3:0] s1_a, s1_b, s1_y, s1_exp;
    logic [3:0] exp_c;
    logic       s1_fail;

    // Golden model; all results wrap to 4 bits.
    always_comb begin
        exp_c = 4'd0;
        case (opcode_in)
            2'b00: exp_c = a_in + b_in;
            2'b01: exp_c = a_in - b_in;
            2'b10: exp_c = a_in & b_in;
            2'b11: exp_c = a_in | b_in;
            default: exp_c = 4'd0;
        endcase
    end

    assign s1_fail    = (s1_y != s1_exp);
    assign halted_out = (state == HALT);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state                <= IDLE;
            s1_vld               <= 1'b0;
            s1_op                <= 2'd0;
            s1_a                 <= 4'd0;
            s1_b                 <= 4'd0;
            s1_y                 <= 4'd0;
            s1_exp               <= 4'd0;
            pass_count_out       <= '0;
            fail_count_out       <= '0;
            mismatch_out         <= 1'b0;
            first_fail_valid_out <= 1'b0;
            first_fail_op_out    <= 2'd0;
            first_fail_a_out     <= 4'd0;
            first_fail_b_out     <= 4'd0;
            first_fail_y_out     <= 4'd0;
            first_fail_exp_out   <= 4'd0;
        end else if (clear_in) begin
            state                <= IDLE;
            s1_vld               <= 1'b0;
            s1_op                <= 2'd0;
            s1_a                 <= 4'd0;
            s1_b                 <= 4'd0;
            s1_y                 <= 4'd0;
            s1_exp               <= 4'd0;
            pass_count_out       <= '0;
            fail_count_out       <= '0;
            mismatch_out         <= 1'b0;
            first_fail_valid_out <= 1'b0;
            first_fail_op_out    <= 2'd0;
            first_fail_a_out     <= 4'd0;
            first_fail_b_out     <= 4'd0;
            first_fail_y_out     <= 4'd0;
            first_fail_exp_out   <= 4'd0;
        end else begin
            mismatch_out <= 1'b0;
            if (state == HALT) begin
                s1_vld <= 1'b0;
            end else begin
                s1_vld <= valid_in;
                if (valid_in) begin
                    s1_op  <= opcode_in;
                    s1_a   <= a_in;
                    s1_b   <= b_in;
                    s1_y   <= y_in;
                    s1_exp <= exp_c;
                    if (state == IDLE) state <= RUN;
                end
                if (s1_vld) begin
                    if (s1_fail) begin
                        mismatch_out <= 1'b1;
                        if (fail_count_out != '1) fail_count_out <= fail_count_out + 1'b1;
                        if (!first_fail_valid_out) begin
                            first_fail_valid_out <= 1'b1;
                            first_fail_op_out    <= s1_op;
                            first_fail_a_out     <= s1_a;
                            first_fail_b_out     <= s1_b;
                            first_fail_y_out     <= s1_y;
                            first_fail_exp_out   <= s1_exp;
                        end
                        // Halting also drops whatever is being sampled on this edge.
                        if (STOP_ON_FAIL) begin
                            state  <= HALT;
                            s1_vld <= 1'b0;
                        end
                    end else if (pass_count_out != '1) begin
                        pass_count_out <= pass_count_out + 1'b1;
                    end
                end
            end
        end
    end

endmodule

// File: tb/tb_alu4_result_checker.sv
// Directed bench for alu4_result_checker: one free-running instance and one with
// STOP_ON_FAIL=1, both fed the same stimulus.
module tb_alu4_result_checker;

    logic       clk = 1'b0;
    logic       rst_n, clear_in, valid_in;
    logic [1:0] opcode_in;
    logic [3:0] a_in, b_in, y_in;

    logic [7:0] p0, f0, p1, f1;
    logic       mm0, ffv0, h0, mm1, ffv1, h1;
    logic [1:0] ffop0, ffop1;
    logic [3:0] ffa0, ffb0, ffy0, ffe0, ffa1, ffb1, ffy1, ffe1;

    int checks = 0;
    int failures = 0;
    int mm_seen = 0;
    bit mon_en = 1'b0;

    always #5 clk = ~clk;

    alu4_result_checker #(.CNT_W(8), .STOP_ON_FAIL(1'b0)) dut0 (
        .clk(clk), .rst_n(rst_n), .clear_in(clear_in), .valid_in(valid_in),
        .opcode_in(opcode_in), .a_in(a_in), .b_in(b_in), .y_in(y_in),
        .pass_count_out(p0), .fail_count_out(f0), .mismatch_out(mm0),
        .first_fail_valid_out(ffv0), .first_fail_op_out(ffop0),
        .first_fail_a_out(ffa0), .first_fail_b_out(ffb0),
        .first_fail_y_out(ffy0), .first_fail_exp_out(ffe0), .halted_out(h0)
    );

    alu4_result_checker #(.CNT_W(8), .STOP_ON_FAIL(1'b1)) dut1 (
        .clk(clk), .rst_n(rst_n), .clear_in(clear_in), .valid_in(valid_in),
        .opcode_in(opcode_in), .a_in(a_in), .b_in(b_in), .y_in(y_in),
        .pass_count_out(p1), .fail_count_out(f1), .mismatch_out(mm1),
        .first_fail_valid_out(ffv1), .first_fail_op_out(ffop1),
        .first_fail_a_out(ffa1), .first_fail_b_out(ffb1),
        .first_fail_y_out(ffy1), .first_fail_exp_out(ffe1), .halted_out(h1)
    );

    always @(negedge clk) if (mon_en && (mm0 || mm1)) mm_seen++;

    task automatic chk(input string tag, input int obs, input int exp);
        checks++;
        if (obs != exp) begin
            failures++;
            $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
        end
    endtask

    // Sweep reference: subtraction via add-of-complement so it is not a copy of the RTL.
    function automatic logic [3:0] ref_y(input logic [1:0] op, input logic [3:0] a, input logic [3:0] b);
        logic [4:0] t;
        case (op)
            2'd0: t = {1'b0, a} + {1'b0, b};
            2'd1: t = {1'b0, a} + {1'b0, ~b} + 5'd1;
            2'd2: t = {1'b0, a & b};
            default: t = {1'b0, a | b};
        endcase
        return t[3:0];
    endfunction

    task automatic drive(input logic [1:0] op, input logic [3:0] a, input logic [3:0] b, input logic [3:0] y);
        valid_in = 1'b1; opcode_in = op; a_in = a; b_in = b; y_in = y;
        @(negedge clk);
    endtask

    task automatic idle(input int n);
        valid_in = 1'b0;
        repeat (n) @(negedge clk);
    endtask

    task automatic do_clear();
        clear_in = 1'b1; valid_in = 1'b0;
        @(negedge clk);
        clear_in = 1'b0;
    endtask

    initial begin
        rst_n = 1'b0; clear_in = 1'b0; valid_in = 1'b0;
        opcode_in = 2'd0; a_in = 4'd0; b_in = 4'd0; y_in = 4'd0;
        repeat (2) @(negedge clk);
        chk("rst_pass", p0, 0);
        chk("rst_fail", f0, 0);
        chk("rst_mm", mm0, 0);
        chk("rst_ffv", ffv0, 0);
        chk("rst_halt", h1, 0);
        rst_n = 1'b1;
        idle(10);
        chk("idle_pass", p0, 0);
        chk("idle_fail", f0, 0);

        // Hand-computed vectors
        drive(2'd0, 4'd9, 4'd8, 4'd1);
        chk("lat_not_yet", p0, 0);
        idle(1);
        chk("add_wrap", p0, 1);
        drive(2'd1, 4'd3, 4'd5, 4'd14);
        idle(1);
        chk("sub_wrap", p0, 2);
        drive(2'd2, 4'd12, 4'd10, 4'd8);
        drive(2'd3, 4'd12, 4'd10, 4'd14);
        idle(1);
        chk("and_or_b2b", p0, 4);
        chk("and_or_b2b_d1", p1, 4);
        chk("dir_fail", f0, 0);
        do_clear();
        chk("clr_pass", p0, 0);

        // Exhaustive correct sweep, back-to-back
        mon_en = 1'b1;
        for (int op = 0; op < 4; op++)
            for (int a = 0; a < 16; a++)
                for (int b = 0; b < 16; b++)
                    drive(op[1:0], a[3:0], b[3:0], ref_y(op[1:0], a[3:0], b[3:0]));
        idle(2);
        mon_en = 1'b0;
        chk("sweep_pass_sat", p0, 255);
        chk("sweep_fail", f0, 0);
        chk("sweep_pass_sat_d1", p1, 255);
        chk("sweep_mm_seen", mm_seen, 0);
        chk("sweep_halt", h1, 0);

        // Fail counts while pass is saturated
        drive(2'd0, 4'd1, 4'd1, 4'd3);
        idle(1);
        chk("sat_fail_inc", f0, 1);
        chk("sat_pass_hold", p0, 255);
        chk("sat_mm", mm0, 1);
        chk("sat_halt_d1", h1, 1);
        do_clear();
        chk("clr_halt", h1, 0);
        chk("clr_ffv", ffv0, 0);

        // Injected error then five good transactions
        drive(2'd2, 4'd12, 4'd10, 4'd9);
        chk("err_mm_early", mm0, 0);
        drive(2'd0, 4'd4, 4'd4, 4'd8);
        chk("err_mm", mm0, 1);
        chk("err_fail", f0, 1);
        chk("ff_valid", ffv0, 1);
        chk("ff_op", ffop0, 2);
        chk("ff_a", ffa0, 12);
        chk("ff_b", ffb0, 10);
        chk("ff_y", ffy0, 9);
        chk("ff_exp", ffe0, 8);
        chk("halt_d1", h1, 1);
        chk("mm_d1", mm1, 1);
        drive(2'd1, 4'd0, 4'd1, 4'd15);
        chk("mm_one_cycle", mm0, 0);
        drive(2'd3, 4'd5, 4'd10, 4'd15);
        drive(2'd2, 4'd15, 4'd6, 4'd6);
        drive(2'd0, 4'd15, 4'd15, 4'd14);
        idle(2);
        chk("after_pass", p0, 5);
        chk("after_fail", f0, 1);
        chk("halt_pass_frozen", p1, 0);
        chk("halt_fail", f1, 1);
        chk("halt_held", h1, 1);
        chk("nohalt_d0", h0, 0);
        drive(2'd1, 4'd2, 4'd3, 4'd0);
        idle(1);
        chk("err2_fail", f0, 2);
        chk("ff_keep_y", ffy0, 9);
        chk("ff_keep_exp", ffe0, 8);
        chk("ff_keep_a", ffa0, 12);
        chk("halt_fail_frozen", f1, 1);
        do_clear();
        chk("clr2_halt", h1, 0);
        chk("clr2_fail_d1", f1, 0);
        chk("clr2_ffv_d1", ffv1, 0);

        // clear and valid together: transaction dropped
        clear_in = 1'b1;
        drive(2'd0, 4'd1, 4'd1, 4'd0);
        clear_in = 1'b0;
        idle(2);
        chk("clrv_fail", f0, 0);
        chk("clrv_pass", p0, 0);
        chk("clrv_mm", mm0, 0);

        // Async reset mid-cycle with transactions in flight
        drive(2'd1, 4'd7, 4'd2, 4'd5);
        drive(2'd3, 4'd1, 4'd2, 4'd3);
        valid_in = 1'b1; opcode_in = 2'd0; a_in = 4'd3; b_in = 4'd3; y_in = 4'd0;
        @(posedge clk);
        #1;
        chk("pre_rst_pass", p0, 2);
        #1 rst_n = 1'b0;
        #1;
        chk("arst_pass", p0, 0);
        chk("arst_fail", f0, 0);
        chk("arst_d1_pass", p1, 0);
        @(negedge clk);
        valid_in = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
        idle(3);
        chk("post_rst_pass", p0, 0);
        chk("post_rst_fail", f0, 0);
        chk("post_rst_ffv", ffv0, 0);
        chk("post_rst_mm", mm0, 0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
